// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gate operand reads in decode.
// Optional macro SCOREBOARD_WB_BYPASS_EN releases a hazard in the cycle its last writeback commits.
module reg_scoreboard #(
   parameter int ADDR_LEN  = 5,
   parameter int REG_COUNT = 32,
   parameter int CNT_W     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 issueEn,
   input  logic                 issueWrites,
   input  logic [ADDR_LEN-1:0]  issueDest,
   input  logic [ADDR_LEN-1:0]  src1,
   input  logic [ADDR_LEN-1:0]  src2,
   input  logic                 src1Used,
   input  logic                 src2Used,
   input  logic                 wbEn,
   input  logic [ADDR_LEN-1:0]  wbDest,
   output logic                 stall,
   output logic                 issueAccept,
   output logic [REG_COUNT-1:0] busyVec,
   output logic                 ovfErr,
   output logic                 udfErr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]     count [REG_COUNT];
   logic [REG_COUNT-1:0] inc_vec;
   logic [REG_COUNT-1:0] dec_vec;
   logic [REG_COUNT-1:0] busy_stall;
   logic [REG_COUNT-1:0] ovf_vec;
   logic [REG_COUNT-1:0] udf_vec;
   logic                 issue_wr;

   // Saturating step; a same-cycle increment and decrement cancel out.
   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic dec);
      if (inc && !dec && c != CNT_MAX) return c + 1'b1;
      if (dec && !inc && c != '0)      return c - 1'b1;
      return c;
   endfunction

   assign issueAccept = issueEn & ~stall & ~flush;
   assign issue_wr    = issueAccept & issueWrites;

   // Register 0 is never tracked, so its decode bits stay low.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      ovf_vec = '0;
      udf_vec = '0;
      busyVec = '0;
      for (int r = 1; r < REG_COUNT; r++) begin
         inc_vec[r] = issue_wr && (issueDest == ADDR_LEN'(r));
         dec_vec[r] = wbEn && (wbDest == ADDR_LEN'(r));
         ovf_vec[r] = inc_vec[r] && !dec_vec[r] && (count[r] == CNT_MAX);
         udf_vec[r] = dec_vec[r] && !inc_vec[r] && (count[r] == '0);
         busyVec[r] = (count[r] != '0);
      end
   end

   always_comb begin
      busy_stall = '0;
      for (int r = 1; r < REG_COUNT; r++) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
         busy_stall[r] = busyVec[r] && !((count[r] == CNT_ONE) && dec_vec[r]);
`else
         busy_stall[r] = busyVec[r];
`endif
      end
   end

   assign stall = issueEn & ((src1Used & busy_stall[src1]) | (src2Used & busy_stall[src2]));

   always_ff @(posedge clk) begin
      for (int r = 0; r < REG_COUNT; r++) begin
         if (rst || flush || r == 0) count[r] <= '0;
         else                        count[r] <= sat_step(count[r], inc_vec[r], dec_vec[r]);
      end
   end

   // Error flags are sticky through flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovfErr <= 1'b0;
         udfErr <= 1'b0;
      end else if (!flush) begin
         ovfErr <= ovfErr | (|ovf_vec);
         udfErr <= udfErr | (|udf_vec);
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (default parameters).
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst, flush, issueEn, issueWrites, src1Used, src2Used, wbEn;
   logic [4:0]  issueDest, src1, src2, wbDest;
   logic        stall, issueAccept, ovfErr, udfErr;
   logic [31:0] busyVec;

   int passed = 0;
   int total  = 0;

   reg_scoreboard dut (
      .clk(clk), .rst(rst), .flush(flush), .issueEn(issueEn),
      .issueWrites(issueWrites), .issueDest(issueDest), .src1(src1), .src2(src2),
      .src1Used(src1Used), .src2Used(src2Used), .wbEn(wbEn), .wbDest(wbDest),
      .stall(stall), .issueAccept(issueAccept), .busyVec(busyVec),
      .ovfErr(ovfErr), .udfErr(udfErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clr();
      rst = 0; flush = 0; issueEn = 0; issueWrites = 0; issueDest = 0;
      src1 = 0; src2 = 0; src1Used = 0; src2Used = 0; wbEn = 0; wbDest = 0;
   endtask

   // Advance one edge, then leave 1 time unit before driving new inputs.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] d);
      clr(); issueEn = 1; issueWrites = 1; issueDest = d; cyc();
   endtask

   task automatic wb(input logic [4:0] d);
      clr(); wbEn = 1; wbDest = d; cyc();
   endtask

   initial begin
      clr(); rst = 1; cyc(); cyc();
      // Post-reset state
      clr(); issueEn = 1; src1 = 3; src1Used = 1; src2 = 9; src2Used = 1; #1;
      chk("rst_busy", busyVec, 0);
      chk("rst_ovf", ovfErr, 0);
      chk("rst_udf", udfErr, 0);
      chk("rst_stall", stall, 0);
      chk("rst_accept", issueAccept, 1);

      // RAW hazard on r5
      clr(); issueEn = 1; issueWrites = 1; issueDest = 5; #1;
      chk("raw_issue_acc", issueAccept, 1);
      cyc();
      clr(); issueEn = 1; src1 = 5; src1Used = 1; #1;
      chk("raw_c1_stall", stall, 1);
      chk("raw_c1_acc", issueAccept, 0);
      chk("raw_c1_busy", busyVec, 32'h20);
      cyc();
      chk("raw_c2_stall", stall, 1);
      src1Used = 0; #1;
      chk("raw_unused_src", stall, 0);
      src1Used = 1;
      cyc();
      wbEn = 1; wbDest = 5; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
      chk("raw_c3_stall", stall, 0);
`else
      chk("raw_c3_stall", stall, 1);
`endif
      chk("raw_c3_busy", busyVec, 32'h20);
      cyc();
      clr(); issueEn = 1; src1 = 5; src1Used = 1; #1;
      chk("raw_c4_stall", stall, 0);
      chk("raw_c4_acc", issueAccept, 1);
      chk("raw_c4_busy", busyVec, 0);

      // Register 0 is ignored
      clr(); issueEn = 1; issueWrites = 1; issueDest = 0;
      src1 = 0; src2 = 0; src1Used = 1; src2Used = 1; #1;
      chk("r0_stall", stall, 0);
      cyc();
      wb(0);
      chk("r0_busy", busyVec, 0);
      chk("r0_ovf", ovfErr, 0);
      chk("r0_udf", udfErr, 0);

      // Simultaneous issue and writeback of r9 at count 1
      issue(9);
      clr(); issueEn = 1; issueWrites = 1; issueDest = 9; wbEn = 1; wbDest = 9; cyc();
      chk("same_busy", busyVec, 32'h200);
      chk("same_ovf", ovfErr, 0);
      chk("same_udf", udfErr, 0);
      wb(9);
      chk("same_release", busyVec, 0);
      chk("same_udf2", udfErr, 0);

      // Saturation on r7
      issue(7); issue(7); issue(7);
      chk("sat_busy3", busyVec, 32'h80);
      chk("sat_ovf_pre", ovfErr, 0);
      issue(7);
      chk("sat_ovf", ovfErr, 1);
      chk("sat_udf_clean", udfErr, 0);
      wb(7); wb(7);
      chk("sat_busy_after2", busyVec, 32'h80);
      wb(7);
      chk("sat_busy_after3", busyVec, 0);
      chk("sat_ovf_sticky", ovfErr, 1);
      chk("sat_no_udf", udfErr, 0);

      // Underflow on r9
      wb(9);
      chk("udf_flag", udfErr, 1);
      chk("udf_busy", busyVec, 0);

      // Flush overrides issue and writeback
      issue(3); issue(4);
      clr(); issueEn = 1; src1 = 3; src2 = 4; src2Used = 1; #1;
      chk("src2_stall", stall, 1);
      chk("flush_pre_busy", busyVec, 32'h18);
      clr(); flush = 1; issueEn = 1; issueWrites = 1; issueDest = 6; wbEn = 1; wbDest = 3; #1;
      chk("flush_acc", issueAccept, 0);
      cyc();
      clr(); #1;
      chk("flush_busy", busyVec, 0);
      chk("flush_ovf", ovfErr, 1);
      chk("flush_udf", udfErr, 1);

      // Reset overrides everything
      issue(3);
      chk("rst2_pre_busy", busyVec, 32'h8);
      clr(); rst = 1; issueEn = 1; issueWrites = 1; issueDest = 4; wbEn = 1; wbDest = 12; cyc();
      clr(); issueEn = 1; src1 = 3; src1Used = 1; src2 = 4; src2Used = 1; #1;
      chk("rst2_busy", busyVec, 0);
      chk("rst2_ovf", ovfErr, 0);
      chk("rst2_udf", udfErr, 0);
      chk("rst2_stall", stall, 0);
      chk("rst2_acc", issueAccept, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
